// File: rtl/rt_pkg.sv
// Shared types and constants for the ray-tracing core.
//   - Q16.16 fixed-point constants
//   - node-record layout (as a packed struct plus explicit bit offsets)
//   - traversal FSM state enum
//   - packed 3-component vector type
//   - saturating 16-bit increment helper
package rt_pkg;

    localparam int W   = 32;    // Q16.16 word
    localparam int NW  = 10;    // node index width
    localparam int IDW = 8;     // ray id width

    localparam logic [W-1:0] Q_ONE = 32'h0001_0000;

    // Node record: {leaf, c1, c0, bmax{z,y,x}, bmin{z,y,x}}
    localparam int NODE_W   = 6*W + 1 + 2*NW;
    localparam int BMIN_LSB = 0;
    localparam int BMAX_LSB = 3*W;
    localparam int C0_LSB   = 6*W;
    localparam int C1_LSB   = 6*W + NW;
    localparam int LEAF_BIT = 6*W + 2*NW;

    typedef struct packed {
        logic [W-1:0] z;
        logic [W-1:0] y;
        logic [W-1:0] x;
    } vec3_t;

    typedef struct packed {
        logic          leaf;
        logic [NW-1:0] c1;
        logic [NW-1:0] c0;
        vec3_t         bmax;
        vec3_t         bmin;
    } node_t;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_RDWAIT = 4'd2,
        ST_TEST   = 4'd3,
        ST_WAIT   = 4'd4,
        ST_DECIDE = 4'd5,
        ST_EMIT   = 4'd6,
        ST_POP    = 4'd7,
        ST_DONE   = 4'd8
    } trav_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trav_stack.sv
// LIFO of node indices for BVH traversal.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the stack)
//   push, push_data push request; dropped when the stack is full
//   pop             pop request; ignored when empty
//   top             entry at the top of the stack (valid when !empty)
//   empty           no entries
//   ovf             one-cycle pulse, registered, after a dropped push
module trav_stack
    import rt_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = NW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] top,
    output logic          empty,
    output logic          ovf
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW = $clog2(DEPTH + 1);

    logic [DW-1:0]  mem_r [DEPTH];
    logic [SPW-1:0] sp_r;
    logic           ovf_r;
    logic           full_s;
    logic           do_pop_s;
    logic           do_push_s;

    assign empty     = (sp_r == SPW'(0));
    assign full_s    = (sp_r == SPW'(DEPTH));
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && !full_s && !do_pop_s;
    // Low pointer bits minus one wraps correctly even when sp == DEPTH.
    assign top       = mem_r[sp_r[AW-1:0] - AW'(1)];
    assign ovf       = ovf_r;

    // Stack pointer and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r  <= '0;
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= push && full_s;
            if (do_pop_s) begin
                sp_r <= sp_r - SPW'(1);
            end else if (do_push_s) begin
                sp_r <= sp_r + SPW'(1);
            end else begin
                sp_r <= sp_r;
            end
        end
    end

    // Entry storage (contents need no reset; sp qualifies them)
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[sp_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/bvh_trav_ctrl.sv
// Per-ray BVH traversal controller. Takes one ray, walks the node table
// depth-first (c0 first, c1 deferred on a stack), issues one box test at a
// time to the AABB intersector, emits leaf candidates and a completion record.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   ray_valid/ray_ready, ray_*        ray offer; ready only when idle
//   node_rd_en/addr/data              node table read, data one cycle later
//   aabb_valid_in, aabb_o/inv/bmin/bmax  box test request and operands
//   aabb_hit, aabb_t_near             result, sampled AABB_LAT cycles after request
//   leaf_valid/ready, leaf_*          leaf candidate handshake
//   done_valid, done_ray_id, done_tests  one-cycle completion record
//   stack_ovf                         sticky, cleared only by rst
module bvh_trav_ctrl
    import rt_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int AABB_LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [IDW-1:0]    ray_id,
    input  logic [3*W-1:0]    ray_o,
    input  logic [3*W-1:0]    ray_inv,
    input  logic [W-1:0]      ray_tmax,
    output logic              node_rd_en,
    output logic [NW-1:0]     node_rd_addr,
    input  logic [NODE_W-1:0] node_rd_data,
    output logic              aabb_valid_in,
    output logic [3*W-1:0]    aabb_o,
    output logic [3*W-1:0]    aabb_inv,
    output logic [3*W-1:0]    aabb_bmin,
    output logic [3*W-1:0]    aabb_bmax,
    input  logic              aabb_hit,
    input  logic [W-1:0]      aabb_t_near,
    output logic              leaf_valid,
    input  logic              leaf_ready,
    output logic [NW-1:0]     leaf_prim,
    output logic [W-1:0]      leaf_t,
    output logic [IDW-1:0]    leaf_ray_id,
    output logic              done_valid,
    output logic [IDW-1:0]    done_ray_id,
    output logic [15:0]       done_tests,
    output logic              stack_ovf
);

    localparam int LATW = (AABB_LAT > 1) ? $clog2(AABB_LAT) : 1;

    trav_state_e     state_r, state_s;
    logic [IDW-1:0]  ray_id_r;
    vec3_t           ray_o_r, ray_inv_r;
    logic [W-1:0]    ray_tmax_r;
    node_t           node_r;
    logic [NW-1:0]   cur_r;
    logic [15:0]     tests_r;
    logic [LATW-1:0] wait_cnt_r;
    logic            hit_r;
    logic [W-1:0]    t_r;
    logic            ray_ready_r, node_rd_en_r, aabb_valid_r;
    logic            leaf_valid_r, done_valid_r, stack_ovf_r;
    logic            push_s, pop_s, empty_s, ovf_s;
    logic [NW-1:0]   top_s;

    trav_stack #(.DEPTH(STACK_DEPTH), .DW(NW)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (node_r.c1),
        .pop       (pop_s),
        .top       (top_s),
        .empty     (empty_s),
        .ovf       (ovf_s)
    );

    // Next-state and stack control
    always_comb begin
        state_s = state_r;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ray_valid && ray_ready_r) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH:  state_s = ST_RDWAIT;
            ST_RDWAIT: state_s = ST_TEST;
            ST_TEST:   state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == LATW'(0)) begin
                    state_s = ST_DECIDE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DECIDE: begin
                if (hit_r && node_r.leaf) begin
                    state_s = ST_EMIT;
                end else if (hit_r) begin
                    // Defer c1; a full stack drops it and we still descend c0.
                    push_s  = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_POP;
                end
            end
            ST_EMIT: begin
                if (leaf_ready) begin
                    state_s = ST_POP;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_POP: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, registered strobes, and traversal datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ray_ready_r  <= 1'b1;
            node_rd_en_r <= 1'b0;
            aabb_valid_r <= 1'b0;
            leaf_valid_r <= 1'b0;
            done_valid_r <= 1'b0;
            stack_ovf_r  <= 1'b0;
            ray_id_r     <= '0;
            ray_o_r      <= '0;
            ray_inv_r    <= '0;
            ray_tmax_r   <= '0;
            node_r       <= '0;
            cur_r        <= '0;
            tests_r      <= 16'd0;
            wait_cnt_r   <= '0;
            hit_r        <= 1'b0;
            t_r          <= '0;
        end else begin
            state_r      <= state_s;
            // Strobes track the state being entered so they align with it.
            ray_ready_r  <= (state_s == ST_IDLE);
            node_rd_en_r <= (state_s == ST_FETCH);
            aabb_valid_r <= (state_s == ST_TEST);
            leaf_valid_r <= (state_s == ST_EMIT);
            done_valid_r <= (state_s == ST_DONE);
            stack_ovf_r  <= stack_ovf_r | ovf_s;
            case (state_r)
                ST_IDLE: begin
                    if (ray_valid && ray_ready_r) begin
                        ray_id_r   <= ray_id;
                        ray_o_r    <= ray_o;
                        ray_inv_r  <= ray_inv;
                        ray_tmax_r <= ray_tmax;
                        cur_r      <= '0;
                        tests_r    <= 16'd0;
                    end
                end
                ST_RDWAIT: node_r <= node_t'(node_rd_data);
                ST_TEST: begin
                    tests_r    <= sat_inc16(tests_r);
                    wait_cnt_r <= LATW'(AABB_LAT - 1);
                end
                ST_WAIT: begin
                    if (wait_cnt_r == LATW'(0)) begin
                        hit_r <= aabb_hit && ($signed(aabb_t_near) <= $signed(ray_tmax_r));
                        t_r   <= aabb_t_near;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - LATW'(1);
                    end
                end
                ST_DECIDE: begin
                    if (hit_r && !node_r.leaf) begin
                        cur_r <= node_r.c0;
                    end
                end
                ST_POP: begin
                    if (!empty_s) begin
                        cur_r <= top_s;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ray_ready     = ray_ready_r;
    assign node_rd_en    = node_rd_en_r;
    assign node_rd_addr  = cur_r;
    assign aabb_valid_in = aabb_valid_r;
    assign aabb_o        = ray_o_r;
    assign aabb_inv      = ray_inv_r;
    assign aabb_bmin     = node_r.bmin;
    assign aabb_bmax     = node_r.bmax;
    assign leaf_valid    = leaf_valid_r;
    assign leaf_prim     = node_r.c0;
    assign leaf_t        = t_r;
    assign leaf_ray_id   = ray_id_r;
    assign done_valid    = done_valid_r;
    assign done_ray_id   = ray_id_r;
    assign done_tests    = tests_r;
    assign stack_ovf     = stack_ovf_r;

endmodule

// File: tb/tb_bvh_trav_ctrl.sv
// Bench for bvh_trav_ctrl: node table memory, a slab-test AABB responder with
// fixed latency, a depth-first traversal reference model, and a per-cycle
// compare process, plus literal expectations for each directed scenario.
module tb_bvh_trav_ctrl;
    import rt_pkg::*;

    localparam int DEPTH = 2;
    localparam int LAT   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ray_valid, ray_ready;
    logic [IDW-1:0]    ray_id;
    logic [3*W-1:0]    ray_o, ray_inv;
    logic [W-1:0]      ray_tmax;
    logic              node_rd_en;
    logic [NW-1:0]     node_rd_addr;
    logic [NODE_W-1:0] node_rd_data;
    logic              aabb_valid_in;
    logic [3*W-1:0]    aabb_o, aabb_inv, aabb_bmin, aabb_bmax;
    logic              aabb_hit;
    logic [W-1:0]      aabb_t_near;
    logic              leaf_valid, leaf_ready;
    logic [NW-1:0]     leaf_prim;
    logic [W-1:0]      leaf_t;
    logic [IDW-1:0]    leaf_ray_id;
    logic              done_valid;
    logic [IDW-1:0]    done_ray_id;
    logic [15:0]       done_tests;
    logic              stack_ovf;

    always #5 clk = ~clk;

    bvh_trav_ctrl #(.STACK_DEPTH(DEPTH), .AABB_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_id(ray_id),
        .ray_o(ray_o), .ray_inv(ray_inv), .ray_tmax(ray_tmax),
        .node_rd_en(node_rd_en), .node_rd_addr(node_rd_addr), .node_rd_data(node_rd_data),
        .aabb_valid_in(aabb_valid_in), .aabb_o(aabb_o), .aabb_inv(aabb_inv),
        .aabb_bmin(aabb_bmin), .aabb_bmax(aabb_bmax),
        .aabb_hit(aabb_hit), .aabb_t_near(aabb_t_near),
        .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_prim(leaf_prim),
        .leaf_t(leaf_t), .leaf_ray_id(leaf_ray_id),
        .done_valid(done_valid), .done_ray_id(done_ray_id), .done_tests(done_tests),
        .stack_ovf(stack_ovf)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- node table ----------------
    logic [NODE_W-1:0] node_mem [0:1023];

    always @(posedge clk) begin
        if (node_rd_en) node_rd_data <= node_mem[node_rd_addr];
    end

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) node_mem[i] = '0;
    endtask

    function automatic logic [NODE_W-1:0] mk(input bit leaf, input int c1, input int c0,
                                             input logic [31:0] lo, input logic [31:0] hi);
        node_t n;
        n.leaf = leaf;
        n.c1 = c1[NW-1:0];
        n.c0 = c0[NW-1:0];
        n.bmin.x = lo; n.bmin.y = lo; n.bmin.z = lo;
        n.bmax.x = hi; n.bmax.y = hi; n.bmax.z = hi;
        return n;
    endfunction

    // ---------------- slab intersection (reference arithmetic) ----------------
    function automatic void slab_axis(input logic [31:0] o, input logic [31:0] iv,
                                      input logic [31:0] mn, input logic [31:0] mx,
                                      inout longint tnear, inout longint tfar);
        longint t1, t2, tmp;
        t1 = ((longint'($signed(mn)) - longint'($signed(o))) * longint'($signed(iv))) >>> 16;
        t2 = ((longint'($signed(mx)) - longint'($signed(o))) * longint'($signed(iv))) >>> 16;
        if (t1 > t2) begin tmp = t1; t1 = t2; t2 = tmp; end
        if (t1 > tnear) tnear = t1;
        if (t2 < tfar) tfar = t2;
    endfunction

    function automatic void slab(input vec3_t o, input vec3_t iv, input vec3_t mn, input vec3_t mx,
                                 output bit hit, output logic [31:0] tn);
        longint tnear, tfar;
        tnear = -(64'sd1 <<< 40);
        tfar  = (64'sd1 <<< 40);
        slab_axis(o.x, iv.x, mn.x, mx.x, tnear, tfar);
        slab_axis(o.y, iv.y, mn.y, mx.y, tnear, tfar);
        slab_axis(o.z, iv.z, mn.z, mx.z, tnear, tfar);
        hit = (tnear <= tfar) && (tfar >= 0);
        tn  = tnear[31:0];
    endfunction

    // ---------------- AABB responder: result valid only in cycle TEST+LAT ----
    int          pend = 0;
    bit          r_hit;
    logic [31:0] r_t;

    always begin
        @(negedge clk); #1;
        aabb_hit    = 1'b0;
        aabb_t_near = 32'h0000_0001;
        if (rst) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    aabb_hit    = r_hit;
                    aabb_t_near = r_t;
                end
            end
            if (aabb_valid_in) begin
                chk("one_in_flight", 64'(pend), 64'd0);
                slab(aabb_o, aabb_inv, aabb_bmin, aabb_bmax, r_hit, r_t);
                pend = LAT;
            end
        end
    end

    // ---------------- traversal reference model ----------------
    typedef struct { logic [NW-1:0] prim; logic [31:0] t; } leaf_rec_t;
    leaf_rec_t   exp_leaves[$];
    int          exp_tests;
    bit          exp_ovf = 1'b0;
    bit          exp_active = 1'b0;
    logic [7:0]  exp_id;

    task automatic run_model(input vec3_t o, input vec3_t iv, input logic [31:0] tmax);
        int stk[$];
        int cur = 0;
        node_t n;
        bit h;
        logic [31:0] t;
        leaf_rec_t rec;
        exp_tests = 0;
        for (int guard = 0; guard < 200; guard++) begin
            n = node_t'(node_mem[cur]);
            slab(o, iv, n.bmin, n.bmax, h, t);
            if (exp_tests < 65535) exp_tests++;
            h = h && ($signed(t) <= $signed(tmax));
            if (h && !n.leaf) begin
                if (stk.size() < DEPTH) stk.push_back(int'(n.c1));
                else exp_ovf = 1'b1;
                cur = int'(n.c0);
                continue;
            end
            if (h) begin
                rec.prim = n.c0; rec.t = t;
                exp_leaves.push_back(rec);
            end
            if (stk.size() == 0) break;
            cur = stk.pop_back();
        end
    endtask

    // ---------------- compare process ----------------
    logic [31:0] got_prim[$];
    logic [31:0] got_t[$];
    int          last_tests;
    bit          stall_prev = 1'b0;
    logic [NW-1:0]  prev_prim;
    logic [31:0]    prev_t;
    logic [IDW-1:0] prev_id;

    always begin
        leaf_rec_t rec;
        @(negedge clk); #1;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(leaf_valid), 64'd1);
                chk("stall_prim", 64'(leaf_prim), 64'(prev_prim));
                chk("stall_t", 64'(leaf_t), 64'(prev_t));
                chk("stall_id", 64'(leaf_ray_id), 64'(prev_id));
            end
            if (leaf_valid) chk("emit_quiet", 64'({node_rd_en, aabb_valid_in}), 64'd0);
            if (exp_active) chk("busy_not_ready", 64'(ray_ready), 64'd0);
            if (leaf_valid && leaf_ready) begin
                chk("leaf_expected", 64'(exp_leaves.size() > 0), 64'd1);
                if (exp_leaves.size() > 0) begin
                    rec = exp_leaves.pop_front();
                    chk("leaf_prim", 64'(leaf_prim), 64'(rec.prim));
                    chk("leaf_t", 64'(leaf_t), 64'(rec.t));
                    chk("leaf_id", 64'(leaf_ray_id), 64'(exp_id));
                end
                got_prim.push_back(32'(leaf_prim));
                got_t.push_back(leaf_t);
            end
            if (done_valid) begin
                chk("done_expected", 64'(exp_active), 64'd1);
                chk("done_id", 64'(done_ray_id), 64'(exp_id));
                chk("done_tests", 64'(done_tests), 64'(exp_tests));
                chk("done_ovf", 64'(stack_ovf), 64'(exp_ovf));
                chk("leaves_left", 64'(exp_leaves.size()), 64'd0);
                last_tests = int'(done_tests);
                exp_active = 1'b0;
            end
            stall_prev = leaf_valid && !leaf_ready;
            prev_prim  = leaf_prim;
            prev_t     = leaf_t;
            prev_id    = leaf_ray_id;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic launch(input logic [7:0] id, input logic [31:0] o,
                          input logic [31:0] iv, input logic [31:0] tmax);
        vec3_t ov, ivv;
        ov.x = o;   ov.y = o;   ov.z = o;
        ivv.x = iv; ivv.y = iv; ivv.z = iv;
        exp_leaves.delete();
        run_model(ov, ivv, tmax);
        exp_id = id;
        got_prim.delete();
        got_t.delete();
        ray_id = id; ray_o = ov; ray_inv = ivv; ray_tmax = tmax;
        ray_valid = 1'b1;
        @(negedge clk);
        ray_valid = 1'b0;
        exp_active = 1'b1;
    endtask

    // Returns cycles from the accept cycle to the done cycle, inclusive.
    task automatic wait_done(output int lat);
        int n = 0;
        while (!done_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done_valid), 64'd1);
        lat = n + 2;
        @(negedge clk);
    endtask

    task automatic tree_single();
        clear_mem();
        node_mem[0] = mk(1'b1, 0, 5, 32'h0000_8000, 32'h0001_8000);
    endtask

    task automatic tree_two();
        clear_mem();
        node_mem[0] = mk(1'b0, 2, 1, 32'h0000_0000, 32'h0004_0000);
        node_mem[1] = mk(1'b1, 0, 3, 32'h0000_8000, 32'h0001_8000);
        node_mem[2] = mk(1'b1, 0, 7, 32'h0002_8000, 32'h0003_8000);
    endtask

    // Interior nodes 0..3 each descend to i+1 and defer 10+i (a missing leaf).
    task automatic tree_chain();
        clear_mem();
        for (int i = 0; i < 4; i++) node_mem[i] = mk(1'b0, 10 + i, i + 1, 32'h0000_0000, 32'h0004_0000);
        node_mem[4] = mk(1'b1, 0, 42, 32'h0000_8000, 32'h0001_8000);
        for (int i = 10; i < 14; i++) node_mem[i] = mk(1'b1, 0, 99, 32'hFFFC_8000, 32'hFFFD_8000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int n;
        rst = 1'b1; ray_valid = 1'b0; ray_id = '0; ray_o = '0; ray_inv = '0; ray_tmax = '0;
        leaf_ready = 1'b1; aabb_hit = 1'b0; aabb_t_near = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_ray_ready", 64'(ray_ready), 64'd1);
        chk("rst_strobes", 64'({node_rd_en, aabb_valid_in, leaf_valid, done_valid, stack_ovf}), 64'd0);
        chk("rst_addr", 64'(node_rd_addr), 64'd0);
        chk("rst_tests", 64'(done_tests), 64'd0);
        chk("rst_aabb_o", 64'(aabb_o[63:0]), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single leaf hit
        tree_single();
        launch(8'h11, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("t1_latency", 64'(lat), 64'd12);
        chk("t1_nleaf", 64'(got_prim.size()), 64'd1);
        if (got_prim.size() > 0) begin
            chk("t1_prim", 64'(got_prim[0]), 64'd5);
            chk("t1_t", 64'(got_t[0]), 64'h8000);
        end
        chk("t1_tests", 64'(last_tests), 64'd1);

        // Ray pointing away: miss
        launch(8'h12, 32'h0, 32'hFFFF_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("t2_nleaf", 64'(got_prim.size()), 64'd0);
        chk("t2_tests", 64'(last_tests), 64'd1);

        // Interior root with two leaves
        tree_two();
        launch(8'h21, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("t3_nleaf", 64'(got_prim.size()), 64'd2);
        if (got_prim.size() == 2) begin
            chk("t3_prim0", 64'(got_prim[0]), 64'd3);
            chk("t3_prim1", 64'(got_prim[1]), 64'd7);
            chk("t3_t0", 64'(got_t[0]), 64'h8000);
            chk("t3_t1", 64'(got_t[1]), 64'h28000);
        end
        chk("t3_tests", 64'(last_tests), 64'd3);

        // tmax culls the far leaf
        launch(8'h22, 32'h0, 32'h0001_0000, 32'h0002_0000);
        wait_done(lat);
        chk("t4_nleaf", 64'(got_prim.size()), 64'd1);
        if (got_prim.size() > 0) chk("t4_prim", 64'(got_prim[0]), 64'd3);
        chk("t4_tests", 64'(last_tests), 64'd3);

        // leaf_ready stall for 10 cycles
        tree_single();
        leaf_ready = 1'b0;
        launch(8'h31, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        n = 0;
        while (!leaf_valid && n < 100) begin @(negedge clk); n++; end
        chk("t5_reach_emit", 64'(leaf_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_valid", 64'(leaf_valid), 64'd1);
            chk("t5_hold_prim", 64'(leaf_prim), 64'd5);
            chk("t5_hold_t", 64'(leaf_t), 64'h8000);
            @(negedge clk);
        end
        leaf_ready = 1'b1;
        wait_done(lat);
        chk("t5_tests", 64'(last_tests), 64'd1);

        // Stack overflow on a left-deep chain (depth 2, four pushes)
        tree_chain();
        chk("t6_ovf_before", 64'(stack_ovf), 64'd0);
        launch(8'h41, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("t6_ovf", 64'(stack_ovf), 64'd1);
        chk("t6_nleaf", 64'(got_prim.size()), 64'd1);
        if (got_prim.size() > 0) chk("t6_prim", 64'(got_prim[0]), 64'd42);
        chk("t6_tests", 64'(last_tests), 64'd7);

        // Reset in the middle of a box-test wait
        launch(8'h42, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        n = 0;
        while (!aabb_valid_in && n < 100) begin @(negedge clk); n++; end
        chk("t7_reach_test", 64'(aabb_valid_in), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        exp_active = 1'b0;
        exp_leaves.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("t7_rst_ready", 64'(ray_ready), 64'd1);
        chk("t7_rst_ovf", 64'(stack_ovf), 64'd0);
        chk("t7_rst_done", 64'(done_valid), 64'd0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        tree_single();
        launch(8'h43, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("t7_tests", 64'(last_tests), 64'd1);
        chk("t7_nleaf", 64'(got_prim.size()), 64'd1);
        tree_two();
        launch(8'h44, 32'h0, 32'h0001_0000, 32'h7FFF_FFFF);
        wait_done(lat);
        chk("t7b_tests", 64'(last_tests), 64'd3);
        chk("t7b_nleaf", 64'(got_prim.size()), 64'd2);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bvh_trav_ctrl.md
Name: bvh_trav_ctrl

Overview:
Per-ray BVH traversal controller; the initiator that drives the aabb_intersect responder.
- Accepts one ray at a time, fetches nodes from the node table, issues box tests, consumes hit/t_near, keeps a traversal stack, and emits leaf candidates plus a per-ray completion record.
- Sits between the ray queue and the primitive-intersection stage of the RT core.

Parameters:
W, 32, fixed-point word width (Q16.16)
NW, 10, node index width
IDW, 8, ray id width
STACK_DEPTH, 16, traversal stack entries
AABB_LAT, 4, cycles from aabb_valid_in assertion to valid hit/t_near

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ray_valid  in  1  ray offer
ray_ready  out  1  high only in IDLE
ray_id  in  IDW  ray tag
ray_o  in  3W  origin {z,y,x}, signed Q16.16
ray_inv  in  3W  inverse direction {z,y,x}
ray_tmax  in  W  maximum t; boxes with t_near > tmax are culled
node_rd_en  out  1  node table read strobe
node_rd_addr  out  NW  node index
node_rd_data  in  6W+1+2NW  {leaf, c1, c0, bmax{z,y,x}, bmin{z,y,x}}, valid 1 cycle after rd_en
aabb_valid_in  out  1  box test request (1-cycle pulse)
aabb_o, aabb_inv  out  3W each  latched ray fields
aabb_bmin, aabb_bmax  out  3W each  latched node box
aabb_hit  in  1  intersector hit
aabb_t_near  in  W  intersector entry t
leaf_valid  out  1  leaf candidate
leaf_ready  in  1  downstream accept
leaf_prim  out  NW  c0 field of leaf node
leaf_t  out  W  t_near of leaf box
leaf_ray_id  out  IDW  ray tag
done_valid  out  1  1-cycle completion pulse
done_ray_id  out  IDW  ray tag
done_tests  out  16  box tests issued for this ray, saturating
stack_ovf  out  1  sticky overflow flag

Behaviour:
- Reset values: all outputs 0 except ray_ready=1; FSM = IDLE; stack pointer 0; test counter 0; stack_ovf cleared only by rst.
- FSM states: IDLE, FETCH, RDWAIT, TEST, WAIT, DECIDE, EMIT, POP, DONE.
- IDLE: on ray_valid && ray_ready, latch the ray; cur=0 (root). Go to FETCH.
- FETCH: node_rd_en=1, node_rd_addr=cur. Go to RDWAIT.
- RDWAIT: latch node_rd_data. Go to TEST.
- TEST: aabb_valid_in=1 for exactly one cycle; aabb_* held stable from TEST until WAIT exits; test counter increments, saturating at 0xFFFF. Go to WAIT.
- WAIT: down-counter; aabb_hit/aabb_t_near are sampled in the cycle exactly AABB_LAT cycles after the TEST cycle. Intersector valid_out is ignored. Go to DECIDE.
- DECIDE:
  - A hit counts only if aabb_hit && aabb_t_near <= ray_tmax, signed compare.
  - Hit on a leaf: go to EMIT.
  - Hit on an interior node: push c1, cur=c0, go to FETCH.
  - Miss: go to POP.
- EMIT: leaf_valid=1 with fields stable until leaf_ready. Valid must not drop without ready. On the handshake, go to POP.
- POP:
  - Stack nonempty: cur = top, sp-1, go to FETCH.
  - Stack empty: go to DONE.
- DONE: done_valid=1 for one cycle with done_ray_id and done_tests. Go to IDLE; test counter clears on the next accept.
- Stack overflow: a push with sp==STACK_DEPTH drops the push, sets stack_ovf, and traversal continues with c0.
- Exactly one box test in flight; no new aabb_valid_in until DECIDE.
- ray_valid while busy: ignored (ray_ready=0).
- Node index c0==cur on an interior node is not checked; software guarantees an acyclic tree.
- rst mid-operation: FSM to IDLE, stack emptied, the in-flight result is discarded, no done_valid is produced for the aborted ray.
- Latency, single-leaf tree, leaf_ready=1: 1 (accept) + FETCH + RDWAIT + TEST + AABB_LAT + DECIDE + EMIT + POP + DONE.

Decomposition:
- Package rt_pkg:
  - Q16.16 constants (ONE=0x0001_0000).
  - Node-record field offsets and widths.
  - FSM state enum.
  - Packed vec3 typedef.
- Sub-module trav_stack: depth STACK_DEPTH, width NW, with push/pop/empty/full and an overflow pulse. It is a natural unit test target.

Test Plan:
- Root leaf box [0x8000..0x18000]^3, c0=5; ray o=0, inv=0x10000, tmax=0x7FFF_FFFF -> one leaf: prim=5, t=0x0000_8000; done_tests=1.
- Same tree, inv=-0x10000 -> no leaf_valid; done_valid with done_tests=1.
- Root interior [0..0x40000]^3 with leaf children [0x8000..0x18000]^3 (c0=3) and [0x28000..0x38000]^3 (c0=7); ray o=0, inv=0x10000:
  - Expect leaves prim 3 then 7, t=0x8000 then 0x28000.
  - Expect done_tests=3.
- Same as the previous case with tmax=0x20000 -> only prim 3; done_tests=3.
- leaf_ready held low 10 cycles -> leaf_valid and fields stable for 10 cycles; no node_rd_en during the stall.
- STACK_DEPTH=2, left-deep chain of 4 interior hits -> stack_ovf=1 after the third push; done_valid still asserted; rst mid-WAIT -> next ray traverses correctly with done_tests counting from 1.
